// File: rtl/uart_cmd_responder.sv
// UART command endpoint: parses ping / register read / register write frames from the host
// and answers each command or aborted frame with exactly one response byte.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT  = 27000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_READY,
  input  logic       TX_IDLE,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY,
  output logic       ERR
);

  localparam int unsigned         CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]     TmoLast = CntW'(TIMEOUT - 1);
  localparam logic [7:0]          OpPing  = 8'h50;
  localparam logic [7:0]          OpRead  = 8'h52;
  localparam logic [7:0]          OpWrite = 8'h57;

  typedef enum logic [2:0] {
    S_OP,
    S_ADDR,
    S_DATA,
    S_RD,
    S_TX,
    S_TXACK
  } state_e;

  state_e          r_state;
  logic            r_rx_q;
  logic            r_is_rd;
  logic [7:0]      r_resp;
  logic [CntW-1:0] r_tmo;

  logic            w_rx_strobe;
  logic            w_tmo_hit;

  // A level held high for several cycles still counts as a single byte.
  assign w_rx_strobe = RX_READY & ~r_rx_q;
  assign w_tmo_hit   = (r_tmo == TmoLast);
  assign BUSY        = (r_state != S_OP);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= S_OP;
      r_rx_q    <= 1'b0;
      r_is_rd   <= 1'b0;
      r_resp    <= 8'h00;
      r_tmo     <= '0;
      TX_DATA   <= 8'h00;
      TX_READY  <= 1'b0;
      REG_ADDR  <= 8'h00;
      REG_WDATA <= 8'h00;
      REG_WE    <= 1'b0;
      REG_RE    <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      r_rx_q <= RX_READY;
      REG_WE <= 1'b0;
      REG_RE <= 1'b0;
      ERR    <= 1'b0;
      r_tmo  <= '0;

      case (r_state)
        S_OP: begin
          if (w_rx_strobe) begin
            case (RX_DATA)
              OpPing: begin
                r_resp  <= OpPing;
                r_state <= S_TX;
              end
              OpRead: begin
                r_is_rd <= 1'b1;
                r_state <= S_ADDR;
              end
              OpWrite: begin
                r_is_rd <= 1'b0;
                r_state <= S_ADDR;
              end
              default: begin
                r_resp  <= NAK_BYTE;
                ERR     <= 1'b1;
                r_state <= S_TX;
              end
            endcase
          end
        end

        S_ADDR: begin
          // A byte arriving on the timeout cycle wins over the abort.
          if (w_rx_strobe) begin
            REG_ADDR <= RX_DATA;
            if (r_is_rd) begin
              REG_RE  <= 1'b1;
              r_state <= S_RD;
            end else begin
              r_state <= S_DATA;
            end
          end else if (w_tmo_hit) begin
            r_resp  <= NAK_BYTE;
            ERR     <= 1'b1;
            r_state <= S_TX;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_DATA: begin
          if (w_rx_strobe) begin
            REG_WDATA <= RX_DATA;
            REG_WE    <= 1'b1;
            r_resp    <= ACK_BYTE;
            r_state   <= S_TX;
          end else if (w_tmo_hit) begin
            r_resp  <= NAK_BYTE;
            ERR     <= 1'b1;
            r_state <= S_TX;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_RD: begin
          if (w_rx_strobe) begin
            ERR <= 1'b1;
          end
          // Read data is valid in the cycle after the REG_RE cycle.
          if (!REG_RE) begin
            r_resp  <= REG_RDATA;
            r_state <= S_TX;
          end
        end

        S_TX: begin
          if (w_rx_strobe) begin
            ERR <= 1'b1;
          end
          if (TX_IDLE) begin
            TX_DATA  <= r_resp;
            TX_READY <= 1'b1;
            r_state  <= S_TXACK;
          end
        end

        S_TXACK: begin
          if (w_rx_strobe) begin
            ERR <= 1'b1;
          end
          if (!TX_IDLE) begin
            TX_READY <= 1'b0;
            r_state  <= S_OP;
          end
        end

        default: begin
          TX_READY <= 1'b0;
          r_state  <= S_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: command vector table plus timeout, busy-sender, reset and
// strobe-width sequences; responses are scored against a queue of expected bytes.
module tb_uart_cmd_responder;

  localparam int unsigned Timeout = 27000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_idle;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .TIMEOUT (Timeout),
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .RX_DATA  (rx_data),
    .RX_READY (rx_ready),
    .TX_DATA  (tx_data),
    .TX_READY (tx_ready),
    .TX_IDLE  (tx_idle),
    .REG_ADDR (reg_addr),
    .REG_WDATA(reg_wdata),
    .REG_WE   (reg_we),
    .REG_RE   (reg_re),
    .REG_RDATA(reg_rdata),
    .BUSY     (busy),
    .ERR      (err)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         we_cnt   = 0;
  int         re_cnt   = 0;
  int         err_cnt  = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [7:0] last_wdata = 8'h00;
  logic [7:0] last_raddr = 8'h00;
  bit         both_strobes = 1'b0;
  bit         tx_seen_high = 1'b0;
  bit         hold = 1'b0;
  logic [7:0] mem [256];

  typedef struct {
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] mem_val;
    logic [7:0] resp;
    int         we;
    int         re;
    int         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Event monitor: strobe counts and last bus values.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_we) begin
        we_cnt++;
        last_waddr = reg_addr;
        last_wdata = reg_wdata;
      end
      if (reg_re) begin
        re_cnt++;
        last_raddr = reg_addr;
      end
      if (err) err_cnt++;
      if (reg_we && reg_re) both_strobes = 1'b1;
      if (tx_ready) tx_seen_high = 1'b1;
    end
  end

  // Register read model: data valid only in the cycle after REG_RE, poison otherwise.
  initial begin
    logic       re_seen;
    logic [7:0] a;
    reg_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      re_seen = reg_re;
      a       = reg_addr;
      @(posedge clk);
      #1;
      reg_rdata = re_seen ? mem[a] : 8'hEE;
    end
  end

  // uart_send model and response scoreboard.
  initial begin
    int         busy_cnt;
    logic [7:0] e;
    busy_cnt = 0;
    tx_idle  = 1'b1;
    forever begin
      @(negedge clk);
      if (hold) begin
        tx_idle  = 1'b0;
        busy_cnt = 0;
      end else if (tx_ready && tx_idle) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_response: actual=%0h required=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("response", 32'(tx_data), 32'(e));
        end
        tx_idle  = 1'b0;
        busy_cnt = 3;
      end else if (!tx_idle) begin
        if (busy_cnt == 0) tx_idle = 1'b1;
        else busy_cnt--;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input int width);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (width) @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (n < bound && !(exp_q.size() == 0 && !busy && tx_idle)) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      failures++;
      $display("FAIL %s_wait: actual=timeout required=done", name);
      exp_q.delete();
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   we0;
    int   re0;
    int   err0;
    int   found_k;

    vecs[0] = '{1, 8'h50, 8'h00, 8'h00, 8'h00, 8'h50, 0, 0, 0};
    vecs[1] = '{3, 8'h57, 8'h3A, 8'hC5, 8'h00, 8'h06, 1, 0, 0};
    vecs[2] = '{2, 8'h52, 8'h3A, 8'h00, 8'h9E, 8'h9E, 0, 1, 0};
    vecs[3] = '{1, 8'h41, 8'h00, 8'h00, 8'h00, 8'h15, 0, 0, 1};
    vecs[4] = '{3, 8'h57, 8'h00, 8'hFF, 8'h00, 8'h06, 1, 0, 0};
    vecs[5] = '{2, 8'h52, 8'hFF, 8'h00, 8'h5A, 8'h5A, 0, 1, 0};
    vecs[6] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h15, 0, 0, 1};
    vecs[7] = '{1, 8'h50, 8'h00, 8'h00, 8'h00, 8'h50, 0, 0, 0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    check("reset_tx_ready", 32'(tx_ready), 32'h0);
    check("reset_reg_bus", 32'({reg_addr, reg_wdata, reg_we, reg_re}), 32'h0);
    check("reset_busy_err", 32'({busy, err}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].b0 == 8'h52) mem[vecs[i].b1] = vecs[i].mem_val;
      we0  = we_cnt;
      re0  = re_cnt;
      err0 = err_cnt;
      exp_q.push_back(vecs[i].resp);
      send_byte(vecs[i].b0, 1);
      if (vecs[i].nbytes > 1) send_byte(vecs[i].b1, 1);
      if (vecs[i].nbytes > 2) send_byte(vecs[i].b2, 1);
      wait_done($sformatf("vec%0d", i), 2000);
      check($sformatf("vec%0d_we_count", i), 32'(we_cnt - we0), 32'(vecs[i].we));
      check($sformatf("vec%0d_re_count", i), 32'(re_cnt - re0), 32'(vecs[i].re));
      check($sformatf("vec%0d_err_count", i), 32'(err_cnt - err0), 32'(vecs[i].err));
      if (vecs[i].we != 0) begin
        check($sformatf("vec%0d_waddr", i), 32'(last_waddr), 32'(vecs[i].b1));
        check($sformatf("vec%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].b2));
      end
      if (vecs[i].re != 0) check($sformatf("vec%0d_raddr", i), 32'(last_raddr), 32'(vecs[i].b1));
    end

    // Timeout in S_DATA: abort exactly TIMEOUT cycles after the address byte.
    we0  = we_cnt;
    err0 = err_cnt;
    exp_q.push_back(8'h15);
    send_byte(8'h57, 1);
    @(negedge clk);
    rx_data  = 8'h10;
    rx_ready = 1'b1;
    found_k  = 0;
    for (int k = 1; k <= int'(Timeout) + 50; k++) begin
      @(negedge clk);
      if (k == 1) rx_ready = 1'b0;
      if (err && found_k == 0) found_k = k;
      if (found_k != 0) break;
    end
    check("timeout_cycle", 32'(found_k), 32'(Timeout + 1));
    wait_done("timeout", 2000);
    check("timeout_no_we", 32'(we_cnt - we0), 32'h0);
    check("timeout_err", 32'(err_cnt - err0), 32'h1);
    exp_q.push_back(8'h50);
    send_byte(8'h50, 1);
    wait_done("ping_after_timeout", 2000);

    // Data byte arriving on the timeout cycle is accepted.
    we0  = we_cnt;
    err0 = err_cnt;
    exp_q.push_back(8'h06);
    send_byte(8'h57, 1);
    @(negedge clk);
    rx_data  = 8'h10;
    rx_ready = 1'b1;
    for (int k = 1; k <= int'(Timeout); k++) begin
      @(negedge clk);
      if (k == 1) rx_ready = 1'b0;
      if (k == int'(Timeout)) begin
        rx_data  = 8'hAB;
        rx_ready = 1'b1;
      end
    end
    @(negedge clk);
    rx_ready = 1'b0;
    wait_done("tmo_boundary", 2000);
    check("tmo_boundary_we", 32'(we_cnt - we0), 32'h1);
    check("tmo_boundary_wdata", 32'(last_wdata), 32'hAB);
    check("tmo_boundary_err", 32'(err_cnt - err0), 32'h0);

    // Busy sender: no TX_READY while idle is low; overrun byte dropped with ERR.
    hold = 1'b1;
    repeat (2) @(negedge clk);
    err0 = err_cnt;
    tx_seen_high = 1'b0;
    exp_q.push_back(8'h50);
    send_byte(8'h50, 1);
    send_byte(8'h41, 1);
    repeat (500) @(negedge clk);
    check("busy_tx_ready_low", 32'(tx_seen_high), 32'h0);
    check("busy_still_busy", 32'(busy), 32'h1);
    check("overrun_err", 32'(err_cnt - err0), 32'h1);
    hold = 1'b0;
    wait_done("busy_release", 2000);
    check("busy_tx_ready_seen", 32'(tx_seen_high), 32'h1);
    check("overrun_err_total", 32'(err_cnt - err0), 32'h1);

    // Reset while waiting in S_DATA abandons the frame.
    we0 = we_cnt;
    send_byte(8'h57, 1);
    send_byte(8'h22, 1);
    check("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_outputs", 32'({tx_ready, reg_we, reg_re, busy, err}), 32'h0);
    check("midreset_bus", 32'({tx_data, reg_addr, reg_wdata}), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_no_we", 32'(we_cnt - we0), 32'h0);
    check("reset_idle", 32'(busy), 32'h0);
    exp_q.push_back(8'h50);
    send_byte(8'h50, 1);
    wait_done("ping_after_reset", 2000);

    // Wide RX_READY pulses count as single bytes.
    err0 = err_cnt;
    re0  = re_cnt;
    exp_q.push_back(8'h50);
    send_byte(8'h50, 5);
    wait_done("wide_ping", 2000);
    exp_q.push_back(8'h9E);
    send_byte(8'h52, 5);
    send_byte(8'h3A, 5);
    wait_done("wide_read", 2000);
    check("wide_err", 32'(err_cnt - err0), 32'h0);
    check("wide_re_count", 32'(re_cnt - re0), 32'h1);
    check("wide_raddr", 32'(last_raddr), 32'h3A);

    check("we_re_exclusive", 32'(both_strobes), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Host-side command endpoint for the camera board's UART link.
- Consumes bytes from uart_receive, parses 1–3 byte commands (ping, register read, register write) and drives a simple register bus toward the sensor-config logic.
- Returns exactly one response byte per command through uart_send.
- Acts as the responder to the host's initiator on the same serial line.

Parameters:
- TIMEOUT, 27000, inter-byte timeout in CLK cycles (1 ms at 27 MHz); a partial frame older than this is aborted.
- ACK_BYTE, 8'h06, response to a successful write.
- NAK_BYTE, 8'h15, response to a bad opcode or timeout.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-low.
- RX_DATA  in  8  received byte from uart_receive DATA.
- RX_READY  in  1  from uart_receive RXD_READY; a byte is taken on its rising edge only.
- TX_DATA  out  8  byte to uart_send DATA.
- TX_READY  out  1  to uart_send DATA_READY.
- TX_IDLE  in  1  from uart_send IDLE.
- REG_ADDR  out  8  register address.
- REG_WDATA  out  8  write data.
- REG_WE  out  1  one-cycle write strobe.
- REG_RE  out  1  one-cycle read strobe.
- REG_RDATA  in  8  read data, valid exactly 1 cycle after REG_RE.
- BUSY  out  1  high in any state other than S_OP.
- ERR  out  1  one-cycle pulse on NAK or dropped byte.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values (RST=0 at a CLK edge):
  - state=S_OP; all outputs 0; TX_DATA=0; timeout counter cleared; RX edge-detect register cleared.
  - Reset mid-frame or mid-transmit abandons everything.
  - TX_READY drops on the same edge.
- Byte strobe: rx_strobe = RX_READY & ~RX_READY_q. A multi-cycle-high RX_READY yields one byte.
- Opcodes: 8'h50 'P' = ping; 8'h52 'R' = read, followed by addr; 8'h57 'W' = write, followed by addr, data.
- States:
  - S_OP: wait for rx_strobe.
    - 'P': resp=8'h50, go to S_TX.
    - 'R': go to S_ADDR, flag rd.
    - 'W': go to S_ADDR, flag wr.
    - Any other value: resp=NAK_BYTE, ERR pulse, go to S_TX.
  - S_ADDR: on rx_strobe, latch REG_ADDR.
    - rd: go to S_RD and pulse REG_RE on entry, in the same cycle REG_ADDR is valid.
    - wr: go to S_DATA.
  - S_DATA: on rx_strobe, REG_WDATA<=byte and REG_WE=1 for exactly 1 cycle; resp=ACK_BYTE; go to S_TX.
  - S_RD: one cycle after the REG_RE cycle, capture REG_RDATA as resp; go to S_TX. Read latency is fixed; no wait states.
  - S_TX: when TX_IDLE=1, drive TX_DATA=resp and TX_READY=1; go to S_TXACK.
  - S_TXACK: hold TX_READY=1 and TX_DATA stable until TX_IDLE=0 (sender accepted), then TX_READY=0 and return to S_OP.
    - TX_DATA keeps its last value after the handshake.
- Timeout:
  - Counter runs in S_ADDR and S_DATA only, and reloads to 0 on each rx_strobe.
  - Reaching TIMEOUT-1 gives resp=NAK_BYTE, ERR pulse, go to S_TX.
  - No REG_WE or REG_RE is issued on abort.
- Dropped bytes: an rx_strobe in S_RD, S_TX or S_TXACK discards the byte and pulses ERR; state is unaffected.
- Simultaneous events: rx_strobe on the timeout cycle counts as the byte arriving, so there is no timeout.
- Ordering: REG_WE and REG_RE are mutually exclusive, and never more than one strobe per command.
- Response count: exactly one response byte per command or abort.
- Pipelining: the next opcode is accepted only after returning to S_OP; there is no command pipelining.

Test Plan:
1. Ping: release RST, host sends 8'h50 -> TX_READY rises with TX_DATA=8'h50 while TX_IDLE=1; no REG strobes; BUSY returns low after TX_IDLE falls.
2. Write: bytes 57,3A,C5 -> single-cycle REG_WE with REG_ADDR=3A and REG_WDATA=C5 on the cycle after the third strobe; response 8'h06.
3. Read: bytes 52,3A, REG_RDATA model returns 8'h9E one cycle after REG_RE -> exactly one REG_RE with REG_ADDR=3A; response 8'h9E.
4. Bad opcode and timeout:
   - Byte 8'h41 -> ERR pulse and response 8'h15.
   - Bytes 57,10 then silence for TIMEOUT cycles -> no REG_WE; ERR pulse; response 8'h15.
   - The next 50 command still answers 50.
5. Busy sender and overrun:
   - Hold TX_IDLE=0 for 500 cycles -> TX_READY stays low, then asserts once TX_IDLE=1.
   - A byte sent during S_TX is dropped with an ERR pulse, and the response value is unchanged.
6. Reset and strobe width:
   - RST=0 asserted in S_DATA, then released -> outputs 0, no REG_WE, state S_OP; a following 50 is answered.
   - RX_READY held high for 5 cycles -> treated as one byte.
